// File: rtl/id_ex_hazard_ctrl_if.sv
// rtl/id_ex_hazard_ctrl_if.sv - ID-stage request and interlock response bundle for id_ex_hazard_ctrl
interface id_ex_hazard_ctrl_if #(
  parameter int REG_AW = 4,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_src0;
  logic [REG_AW-1:0] id_src1;
  logic              id_use0;
  logic              id_use1;
  logic              id_write;
  logic [REG_AW-1:0] id_writeReg;
  logic              flush;
  logic              stall;
  logic              bubble;
  logic [DEPTH-1:0]  busy_mask;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_src0, id_src1, id_use0, id_use1, id_write, id_writeReg, flush,
    input  stall, bubble, busy_mask, stall_cnt
  );

  modport slave (
    input  id_valid, id_src0, id_src1, id_use0, id_use1, id_write, id_writeReg, flush,
    output stall, bubble, busy_mask, stall_cnt
  );
endinterface

// File: rtl/id_ex_hazard_ctrl.sv
// rtl/id_ex_hazard_ctrl.sv - RAW interlock for the ID/EX latch (no forwarding)
// Scoreboard of in-flight writes, EX (entry 0) through writeback (entry DEPTH-1).
module id_ex_hazard_ctrl #(
  parameter int REG_AW = 4,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  id_ex_hazard_ctrl_if.slave bus
);
  typedef enum logic {S_RUN, S_HOLD} state_t;

  logic [DEPTH-1:0]  r_v;
  logic [REG_AW-1:0] r_reg [DEPTH];
  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_cnt_en;
  logic              w_match0;
  logic              w_match1;
  logic              w_hazard;
  logic              w_stall;
  logic              w_ins;

  always_comb begin
    w_match0 = 1'b0;
    w_match1 = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_v[k] && (r_reg[k] == bus.id_src0)) w_match0 = 1'b1;
      if (r_v[k] && (r_reg[k] == bus.id_src1)) w_match1 = 1'b1;
    end
  end

  assign w_hazard = bus.id_valid & ((bus.id_use0 & w_match0) | (bus.id_use1 & w_match1));
  assign w_stall  = w_hazard & ~bus.flush;
  // A stalled or killed ID instruction leaves an empty slot behind it.
  assign w_ins    = bus.id_valid & bus.id_write & ~w_stall & ~bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= '0;
      for (int k = 0; k < DEPTH; k++) r_reg[k] <= '0;
    end else begin
      r_v      <= {r_v[DEPTH-2:0], w_ins};
      r_reg[0] <= bus.id_writeReg;
      for (int k = 1; k < DEPTH; k++) r_reg[k] <= r_reg[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_en    = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_stall) begin
          w_state_nxt = S_HOLD;
          w_cnt_en    = 1'b1;
        end
      end
      S_HOLD: begin
        if (w_stall) w_cnt_en    = 1'b1;
        else         w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_cnt <= '0;
    else if (w_cnt_en && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end

  assign bus.stall     = w_stall;
  assign bus.bubble    = w_stall | bus.flush;
  assign bus.busy_mask = r_v;
  assign bus.stall_cnt = r_cnt;
endmodule
